// File: rtl/pixel_tile_arbiter.sv
// Groups a pixel event array into GRP x GRP tiles, requests per tile upward,
// and drains an enabled tile round-robin as registered valid/ready events.
module pixel_tile_arbiter #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int POLARITY = 2,
  parameter int GRP      = 4,
  parameter int GR       = ROWS / GRP,
  parameter int GC       = COLS / GRP,
  parameter int XW       = $clog2(ROWS),
  parameter int YW       = $clog2(COLS)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] req_i,
  input  logic [GR-1:0][GC-1:0]                  enable_i,
  output logic [GR-1:0][GC-1:0]                  req_o,
  output logic                                   evt_valid_o,
  input  logic                                   evt_ready_i,
  output logic [XW-1:0]                          evt_x_o,
  output logic [YW-1:0]                          evt_y_o,
  output logic [POLARITY-1:0]                    evt_pol_o,
  output logic [ROWS-1:0][COLS-1:0]              gnt_out_o,
  output logic                                   grp_release_o,
  output logic                                   active_o
);

  localparam int NG = GR * GC;
  localparam int NL = GRP * GRP;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

  state_t state, state_n;

  logic [ROWS-1:0][COLS-1:0] served;
  logic [LW-1:0]             ptr [NG];
  logic [GW-1:0]             g_cur, grp, sel_g;
  logic [LW-1:0]             cur_idx, start, pick;
  logic                      sel_ok, found, load, hs, clr;
  logic [NG-1:0][NL-1:0]     gpend;
  logic [NG-1:0][NL-1:0][POLARITY-1:0] gpol;
  logic [NG-1:0]             en_flat;
  logic [NL-1:0]             lp;

  // Regroup the array as [group][local index] so tiles index by one value.
  always_comb begin
    gpend = '0;
    gpol  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        gpend[(r/GRP)*GC + c/GRP][(r%GRP)*GRP + c%GRP] =
          (|req_i[r][c]) & ~served[r][c];
        gpol[(r/GRP)*GC + c/GRP][(r%GRP)*GRP + c%GRP] = req_i[r][c];
      end
    end
  end

  always_comb begin
    req_o   = '0;
    en_flat = '0;
    for (int g = 0; g < NG; g++) begin
      req_o[g/GC][g%GC] = |gpend[g];
      en_flat[g]        = enable_i[g/GC][g%GC];
    end
  end

  always_comb begin
    sel_g  = '0;
    sel_ok = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (en_flat[g]) begin
        sel_g  = GW'(g);
        sel_ok = 1'b1;
      end
    end
  end

  // While serving, the pixel in flight is excluded so the next pick is ready
  // in the same cycle as its handshake.
  always_comb begin
    logic [LW-1:0] j;
    j     = '0;
    grp   = (state == IDLE) ? sel_g : g_cur;
    start = (state == IDLE) ? ptr[sel_g] : cur_idx;
    lp    = gpend[grp];
    if (state != IDLE) lp[cur_idx] = 1'b0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NL; k++) begin
      j = LW'((int'(start) + k) % NL);
      if (!found && lp[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    hs      = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_ok && found) begin
          load    = 1'b1;
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (evt_ready_i) begin
          hs = 1'b1;
          if (!en_flat[g_cur]) state_n = IDLE;
          else if (found)      load    = 1'b1;
          else                 state_n = RELEASE;
        end
      end
      RELEASE: begin
        clr     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign evt_valid_o   = (state == SERVE);
  assign grp_release_o = (state == RELEASE);
  assign active_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      served    <= '0;
      g_cur     <= '0;
      cur_idx   <= '0;
      evt_x_o   <= '0;
      evt_y_o   <= '0;
      evt_pol_o <= '0;
      gnt_out_o <= '0;
      for (int g = 0; g < NG; g++) ptr[g] <= LW'(NL - 1);
    end else begin
      gnt_out_o <= '0;
      if (hs) begin
        served[evt_x_o][evt_y_o]    <= 1'b1;
        gnt_out_o[evt_x_o][evt_y_o] <= 1'b1;
        ptr[g_cur]                  <= cur_idx;
      end
      if (clr) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (((r/GRP)*GC + c/GRP) == int'(g_cur)) served[r][c] <= 1'b0;
      end
      if (load) begin
        g_cur     <= grp;
        cur_idx   <= pick;
        evt_x_o   <= XW'((int'(grp) / GC) * GRP + int'(pick) / GRP);
        evt_y_o   <= YW'((int'(grp) % GC) * GRP + int'(pick) % GRP);
        evt_pol_o <= gpol[grp][pick];
      end
    end
  end

endmodule

// File: tb/tb_pixel_tile_arbiter.sv
// Directed bench for pixel_tile_arbiter: single-event table plus
// hand-written multi-cycle sequences.
module tb_pixel_tile_arbiter;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [7:0][7:0][1:0]  req;
  logic [1:0][1:0]       en;
  logic [1:0][1:0]       req_o;
  logic                  rdy;
  logic                  evt_valid_o;
  logic [2:0]            evt_x_o;
  logic [2:0]            evt_y_o;
  logic [1:0]            evt_pol_o;
  logic [7:0][7:0]       gnt_out_o;
  logic                  grp_release_o;
  logic                  active_o;

  int total = 0;
  int pass  = 0;

  pixel_tile_arbiter dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_i         (req),
    .enable_i      (en),
    .req_o         (req_o),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (rdy),
    .evt_x_o       (evt_x_o),
    .evt_y_o       (evt_y_o),
    .evt_pol_o     (evt_pol_o),
    .gnt_out_o     (gnt_out_o),
    .grp_release_o (grp_release_o),
    .active_o      (active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] pol;
    int         gr;
    int         gc;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] oh(input int x, input int y);
    return 64'd1 << (x * 8 + y);
  endfunction

  task automatic chk_evt(input string nm, input int x, input int y,
                         input logic [1:0] p);
    chk({nm, ".valid"}, evt_valid_o, 1);
    chk({nm, ".x"}, evt_x_o, x);
    chk({nm, ".y"}, evt_y_o, y);
    chk({nm, ".pol"}, evt_pol_o, p);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2, 5, 2'b01, 0, 1};
    tbl[1] = '{0, 0, 2'b10, 0, 0};
    tbl[2] = '{7, 7, 2'b11, 1, 1};
    tbl[3] = '{4, 3, 2'b01, 1, 0};
    tbl[4] = '{5, 2, 2'b10, 1, 0};

    reset_i = 1'b1;
    req = '0;
    en  = '0;
    rdy = 1'b0;
    step();
    step();
    chk("rst.valid", evt_valid_o, 0);
    chk("rst.x", evt_x_o, 0);
    chk("rst.y", evt_y_o, 0);
    chk("rst.pol", evt_pol_o, 0);
    chk("rst.gnt", gnt_out_o, 0);
    chk("rst.rel", grp_release_o, 0);
    chk("rst.active", active_o, 0);
    chk("rst.req_o", req_o, 0);
    reset_i = 1'b0;

    // single-pixel events across all groups
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req = '0;
      req[tbl[i].x][tbl[i].y] = tbl[i].pol;
      #1;
      chk("t1.req_o", req_o, 64'd1 << (tbl[i].gr * 2 + tbl[i].gc));
      en[tbl[i].gr][tbl[i].gc] = 1'b1;
      step();
      chk_evt("t1", tbl[i].x, tbl[i].y, tbl[i].pol);
      step();
      chk("t1.gnt", gnt_out_o, oh(tbl[i].x, tbl[i].y));
      chk("t1.rel", grp_release_o, 1);
      chk("t1.req_served", req_o, 0);
      chk("t1.valid_lo", evt_valid_o, 0);
      req = '0;
      en  = '0;
      step();
      chk("t1.idle", active_o, 0);
      chk("t1.rel_lo", grp_release_o, 0);
      chk("t1.gnt_lo", gnt_out_o, 0);
    end

    // back-to-back round in group 0
    do_reset();
    req[0][0] = 2'b01;
    req[1][1] = 2'b10;
    req[3][3] = 2'b11;
    en[0][0]  = 1'b1;
    rdy = 1'b1;
    step();
    chk_evt("t2.e0", 0, 0, 2'b01);
    step();
    chk_evt("t2.e1", 1, 1, 2'b10);
    chk("t2.gnt0", gnt_out_o, oh(0, 0));
    step();
    chk_evt("t2.e2", 3, 3, 2'b11);
    chk("t2.gnt1", gnt_out_o, oh(1, 1));
    step();
    chk("t2.valid_lo", evt_valid_o, 0);
    chk("t2.rel", grp_release_o, 1);
    chk("t2.gnt2", gnt_out_o, oh(3, 3));
    en  = '0;
    req = '0;
    step();
    chk("t2.active_lo", active_o, 0);
    chk("t2.rel_lo", grp_release_o, 0);

    // backpressure; request drops after capture
    do_reset();
    req[6][1] = 2'b10;
    en[1][0]  = 1'b1;
    rdy = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk_evt("t3.hold", 6, 1, 2'b10);
      chk("t3.gnt_lo", gnt_out_o, 0);
      if (i == 2) req = '0;
      if (i == 5) rdy = 1'b1;
      step();
    end
    chk("t3.gnt", gnt_out_o, oh(6, 1));
    chk("t3.rel", grp_release_o, 1);
    en = '0;
    step();
    chk("t3.gnt_once", gnt_out_o, 0);
    chk("t3.idle", active_o, 0);

    // enable drops mid-round; round resumes later
    do_reset();
    req[0][0] = 2'b01;
    req[0][1] = 2'b01;
    req[0][2] = 2'b01;
    en[0][0]  = 1'b1;
    rdy = 1'b1;
    step();
    chk_evt("t4.e0", 0, 0, 2'b01);
    step();
    chk_evt("t4.e1", 0, 1, 2'b01);
    en = '0;
    step();
    chk("t4.valid_lo", evt_valid_o, 0);
    chk("t4.idle", active_o, 0);
    chk("t4.no_rel", grp_release_o, 0);
    chk("t4.gnt1", gnt_out_o, oh(0, 1));
    chk("t4.req_o", req_o, 4'b0001);
    step();
    chk("t4.still_idle", evt_valid_o, 0);
    en[0][0] = 1'b1;
    step();
    chk_evt("t4.e2", 0, 2, 2'b01);
    step();
    chk("t4.rel", grp_release_o, 1);
    chk("t4.gnt2", gnt_out_o, oh(0, 2));
    en  = '0;
    req = '0;
    step();
    chk("t4.end", active_o, 0);

    // two enabled groups: lowest index wins
    do_reset();
    req[0][0] = 2'b01;
    req[5][6] = 2'b10;
    en[0][0]  = 1'b1;
    en[1][1]  = 1'b1;
    rdy = 1'b0;
    #1;
    chk("t5.req_o", req_o, 4'b1001);
    step();
    chk_evt("t5.g0", 0, 0, 2'b01);
    en[0][0] = 1'b0;
    rdy = 1'b1;
    step();
    chk("t5.valid_lo", evt_valid_o, 0);
    chk("t5.no_rel", grp_release_o, 0);
    chk("t5.gnt0", gnt_out_o, oh(0, 0));
    step();
    chk_evt("t5.g3", 5, 6, 2'b10);
    step();
    chk("t5.rel", grp_release_o, 1);
    chk("t5.gnt3", gnt_out_o, oh(5, 6));
    en  = '0;
    req = '0;
    step();

    // reset during SERVE; pointers restart at local index 0
    req[4][4] = 2'b01;
    req[6][6] = 2'b10;
    en[1][1]  = 1'b1;
    rdy = 1'b0;
    step();
    chk_evt("t6.pre", 6, 6, 2'b10);
    rdy = 1'b1;
    reset_i = 1'b1;
    step();
    chk("t6.valid", evt_valid_o, 0);
    chk("t6.x", evt_x_o, 0);
    chk("t6.y", evt_y_o, 0);
    chk("t6.pol", evt_pol_o, 0);
    chk("t6.gnt", gnt_out_o, 0);
    chk("t6.rel", grp_release_o, 0);
    chk("t6.active", active_o, 0);
    reset_i = 1'b0;
    rdy = 1'b0;
    step();
    chk_evt("t6.post", 4, 4, 2'b01);
    rdy = 1'b1;
    step();
    chk_evt("t6.next", 6, 6, 2'b10);
    chk("t6.gnt44", gnt_out_o, oh(4, 4));
    step();
    chk("t6.rel_end", grp_release_o, 1);
    chk("t6.gnt66", gnt_out_o, oh(6, 6));
    en  = '0;
    req = '0;
    step();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
